// File: rtl/ble_rx_queue.sv
// rtl/ble_rx_queue.sv - UART byte FIFO draining into a circular RAM window as word writes
module ble_rx_queue #(
    parameter int          BITS   = 8,
    parameter int          DEPTH  = 8,
    parameter logic [31:0] ADR_LL = 32'h00C00000,
    parameter logic [31:0] ADR_UL = 32'h00C10000
) (
    input  logic                     i_wb_clk,
    input  logic                     i_wb_rst,
    input  logic [BITS-1:0]          i_rx_dat,
    input  logic                     i_rx_done,
    input  logic                     i_cpu_cyc,
    output logic [31:0]              o_wb_adr,
    output logic                     o_wb_cyc,
    output logic                     o_wb_we,
    output logic [3:0]               o_wb_sel,
    output logic [31:0]              o_wb_dat,
    input  logic                     i_wb_ack,
    output logic                     o_grant,
    output logic [31:0]              o_wr_ptr,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    input  logic                     i_clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          r_state;
    logic [BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_rd_idx;
    logic [AW-1:0]   r_wr_idx;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [31:0]     r_wr_ptr;
    logic [31:0]     r_wb_adr;
    logic            r_wb_cyc;
    logic            r_wb_we;
    logic [3:0]      r_wb_sel;
    logic [31:0]     r_wb_dat;
    logic            r_grant;

    logic            w_pop;
    logic            w_full;
    logic            w_push_ok;
    logic            w_push_drop;
    logic [32:0]     w_ptr_inc;
    logic [31:0]     w_ptr_next;
    logic [31:0]     w_head_word;

    // The head leaves the FIFO only when the RAM acknowledges its write.
    assign w_pop       = (r_state == S_WRITE) && i_wb_ack;
    assign w_full      = (r_count == CW'(DEPTH));
    // A pop in the same cycle frees a slot, so a push onto a full FIFO still lands.
    assign w_push_ok   = i_rx_done && (!w_full || w_pop);
    assign w_push_drop = i_rx_done && w_full && !w_pop;
    // 33-bit sum so a window ending near the top of the address space cannot wrap silently.
    assign w_ptr_inc   = {1'b0, r_wr_ptr} + 33'd4;
    assign w_ptr_next  = (w_ptr_inc >= {1'b0, ADR_UL}) ? ADR_LL : w_ptr_inc[31:0];
    assign w_head_word = 32'(r_mem[r_rd_idx]);

    assign o_wb_adr   = r_wb_adr;
    assign o_wb_cyc   = r_wb_cyc;
    assign o_wb_we    = r_wb_we;
    assign o_wb_sel   = r_wb_sel;
    assign o_wb_dat   = r_wb_dat;
    assign o_grant    = r_grant;
    assign o_wr_ptr   = r_wr_ptr;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

    // Byte storage; contents need no reset because the indices define validity.
    always_ff @(posedge i_wb_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_idx] <= i_rx_dat;
        end
    end

    // FIFO indices and occupancy; push and pop in one cycle leave the count unchanged.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            r_rd_idx <= '0;
            r_wr_idx <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_idx <= r_wr_idx + AW'(1);
            end
            if (w_pop) begin
                r_rd_idx <= r_rd_idx + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky drop flag; a new drop in the same cycle as a clear keeps it set.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            r_overflow <= 1'b0;
        end else if (w_push_drop) begin
            r_overflow <= 1'b1;
        end else if (i_clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    // Bus sequencer: claim the RAM only when the CPU is idle, hold the cycle until ack,
    // then keep the grant one extra cycle so the RAM ack drains before the CPU is reconnected.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            r_state  <= S_IDLE;
            r_wb_adr <= '0;
            r_wb_cyc <= 1'b0;
            r_wb_we  <= 1'b0;
            r_wb_sel <= 4'b0000;
            r_wb_dat <= '0;
            r_grant  <= 1'b0;
            r_wr_ptr <= ADR_LL;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if ((r_count != '0) && !i_cpu_cyc) begin
                        r_state  <= S_WRITE;
                        r_grant  <= 1'b1;
                        r_wb_cyc <= 1'b1;
                        r_wb_we  <= 1'b1;
                        r_wb_sel <= 4'b1111;
                        r_wb_adr <= r_wr_ptr;
                        r_wb_dat <= w_head_word;
                    end
                end
                S_WRITE: begin
                    if (i_wb_ack) begin
                        r_state  <= S_GAP;
                        r_wb_cyc <= 1'b0;
                        r_wb_we  <= 1'b0;
                        r_wb_sel <= 4'b0000;
                        r_wr_ptr <= w_ptr_next;
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                    r_grant <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_wb_cyc <= 1'b0;
                    r_wb_we  <= 1'b0;
                    r_wb_sel <= 4'b0000;
                    r_grant  <= 1'b0;
                end
            endcase
        end
    end

endmodule
